dll_rx_ack_gen: RTL
===================

# dll_rx_ack_gen

Receive-side data-link-layer block that pairs with the transmit-side replay buffer. It checks the sequence number and LCRC status of each incoming TLP and forwards in-order good TLPs to the transaction layer. It schedules ACK/NAK DLLPs carrying the 12-bit sequence number that the replay buffer consumes on its `ack_nak`/`seq` inputs, and coalesces ACKs with a latency timer.

## Interface
- `SEQ_W`, 12, sequence-number width; arithmetic is modulo 2^SEQ_W
- `DATA_W`, 64, TLP data width
- `ACK_LAT`, 16, ACK coalescing latency in cycles (≥2)

- `clk`  in  1  clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `tlp_valid`  in  1  received TLP present (one beat per TLP)
- `tlp_ready`  out  1  block accepts TLP; transfer when `tlp_valid & tlp_ready`
- `tlp_seq`  in  SEQ_W  sequence number of presented TLP
- `tlp_crc_err`  in  1  LCRC check failed for presented TLP
- `din`  in  DATA_W  TLP payload
- `dout`  out  DATA_W  forwarded good TLP payload
- `dout_valid`  out  1  `dout` valid, one-cycle pulse per good TLP
- `dllp_valid`  out  1  ACK/NAK DLLP pending
- `dllp_ready`  in  1  DLLP consumer accepts; transfer when both high
- `ack_nak`  out  2  0 = none, 1 = ACK, 2 = NAK (3 unused)
- `ack_seq`  out  SEQ_W  sequence number carried by DLLP

## Operation
- State: `next_rcv_seq` (SEQ_W), `nak_sched` flag, `ack_pend` flag, `pend_seq`, FSM {IDLE, ACK_PEND, SEND_ACK, SEND_NAK}.
- On each accepted TLP, classify in priority order:
  - `tlp_crc_err=1`: discard. If `!nak_sched`, set `nak_sched` and go to SEND_NAK with `ack_seq = next_rcv_seq-1`.
  - `tlp_seq == next_rcv_seq`: forward to `dout`, increment `next_rcv_seq` (wrap 4095→0), clear `nak_sched`, set `ack_pend`, set `pend_seq = tlp_seq`.
  - Duplicate, i.e. `(next_rcv_seq - tlp_seq) mod 2^SEQ_W` in 1..2048: discard. Go to SEND_ACK with `ack_seq = next_rcv_seq-1`; this clears `ack_pend`.
  - Otherwise (ahead / lost TLP): discard. If `!nak_sched`, schedule NAK as for the CRC error case.
- IDLE→ACK_PEND on first good TLP; the timer starts. ACK_PEND→SEND_ACK on timer expiry, with `ack_seq = pend_seq`.
- SEND_ACK/SEND_NAK hold `dllp_valid`, `ack_nak`, `ack_seq` stable until `dllp_ready`, then go to IDLE. On SEND_ACK exit, clear `ack_pend`.
- A NAK overrides a pending ACK: `ack_pend` is cleared, because the NAK sequence number acknowledges everything before it.
- `tlp_ready = 0` in SEND_ACK/SEND_NAK; otherwise `tlp_ready = 1`.
- When `nak_sched` is set, further bad/ahead TLPs produce no extra NAK until a good TLP clears it.

## Timing
- Reset values: `tlp_ready=1`, `dout=0`, `dout_valid=0`, `dllp_valid=0`, `ack_nak=0`, `ack_seq=0`, `next_rcv_seq=0`, flags clear, FSM IDLE.
- `dout`/`dout_valid`: registered, valid at edge N+1 for a TLP accepted at edge N.
- NAK or duplicate-ACK: `dllp_valid` is high from edge N+1.
- Coalesced ACK: first good TLP accepted at edge N gives `dllp_valid` at edge N+ACK_LAT. Later good TLPs in the window only update `pend_seq`; they do not restart the timer.
- If `dllp_ready` is already high when `dllp_valid` rises, the DLLP is held exactly one cycle.
- Reset asserted mid-operation drops any pending or presented DLLP and timer state at the next edge.

## Configuration
- `ACK_COALESCE_EN` defined: ACK timer active as above.
- `ACK_COALESCE_EN` undefined: no timer, and ACK_PEND is never entered. Each good TLP goes directly to SEND_ACK (`dllp_valid` at N+1, `ack_seq = tlp_seq`), and `ACK_LAT` is ignored.

## Structure
- Shared package `dll_pkg`:
  - `SEQ_W` constant
  - `ack_nak_t` enum {NONE=0, ACK=1, NAK=2}, shared with the replay buffer
  - FSM state enum
  - `seq_dist` function (modulo difference)
- One sub-module: `dll_ack_timer`, a loadable down-counter with start/clear/expire, instantiated only under `ACK_COALESCE_EN`.

## Test plan
- Reset, then TLPs seq 0,1,2 back-to-back with `dllp_ready=1` → `dout` pulses 0,1,2. With the macro defined: one ACK, `ack_seq=2`, at ACK_LAT cycles after seq 0. Without the macro: three ACKs, seq 0,1,2.
- `next_rcv_seq=3`, TLP seq 3 with `tlp_crc_err=1`, then seq 5 → exactly one NAK with `ack_seq=2`, no `dout`. Then seq 3 good → `dout` pulse and `nak_sched` cleared.
- `next_rcv_seq=4`, duplicate seq 1 → no `dout`, ACK with `ack_seq=3` at N+1.
- Wrap: preload to seq 4095, send 4095 then 0 → both forwarded, final ACK `ack_seq=0`, `next_rcv_seq=1`.
- Hold `dllp_ready=0` for 5 cycles during NAK → outputs stable, `tlp_ready=0`. Assert `reset` mid-hold → all outputs at reset values next cycle.

Source files
------------

// File: rtl/dll_pkg.sv
// dll_pkg: types, constants and helpers shared by the data-link-layer
// receive ACK/NAK generator and the transmit-side replay buffer.
package dll_pkg;

  // Sequence-number width; all sequence arithmetic wraps modulo 2^SEQ_W
  localparam int SEQ_W = 12;

  // Largest backward distance still treated as a duplicate (half the space)
  localparam logic [SEQ_W-1:0] DUP_WIN = SEQ_W'(32'd1 << (SEQ_W - 1));

  // DLLP type carried to the replay buffer
  typedef enum logic [1:0] {
    NONE = 2'd0,
    ACK  = 2'd1,
    NAK  = 2'd2
  } ack_nak_t;

  // Receive-side ACK/NAK scheduler states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACK_PEND = 2'd1,
    ST_SEND_ACK = 2'd2,
    ST_SEND_NAK = 2'd3
  } rx_state_t;

  // Modulo distance a - b in sequence space
  function automatic logic [SEQ_W-1:0] seq_dist(input logic [SEQ_W-1:0] a,
                                                 input logic [SEQ_W-1:0] b);
    return a - b;
  endfunction

endpackage

// File: rtl/dll_rx_ack_gen_if.sv
// dll_rx_ack_gen_if: TLP receive handshake, forwarded payload and ACK/NAK
// DLLP handshake of the receive-side data-link block.
interface dll_rx_ack_gen_if #(
  parameter int DATA_W = 64
);
  import dll_pkg::*;

  logic              tlp_valid;
  logic              tlp_ready;
  logic [SEQ_W-1:0]  tlp_seq;
  logic              tlp_crc_err;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dllp_valid;
  logic              dllp_ready;
  ack_nak_t          ack_nak;
  logic [SEQ_W-1:0]  ack_seq;

  // Receive block side
  modport slave (
    input  tlp_valid, tlp_seq, tlp_crc_err, din, dllp_ready,
    output tlp_ready, dout, dout_valid, dllp_valid, ack_nak, ack_seq
  );

  // Link / consumer side
  modport master (
    output tlp_valid, tlp_seq, tlp_crc_err, din, dllp_ready,
    input  tlp_ready, dout, dout_valid, dllp_valid, ack_nak, ack_seq
  );

endinterface

// File: rtl/dll_ack_timer.sv
// dll_ack_timer: loadable down-counter used to coalesce ACKs. A start
// loads ACK_LAT-2 so that the registered DLLP valid lands ACK_LAT cycles
// after the starting TLP edge; o_expire is high for the last counting cycle.
module dll_ack_timer #(
  parameter int ACK_LAT = 16
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_start,
  input  logic i_clear,
  output logic o_expire
);

  localparam int               CNT_W    = $clog2(ACK_LAT) + 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(ACK_LAT - 2);

  logic [CNT_W-1:0] r_cnt;
  logic             r_run;

  // Load on start, count down while running, stop on clear or after expiry
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (i_clear) begin
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (i_start) begin
      r_cnt <= LOAD_VAL;
      r_run <= 1'b1;
    end else if (r_run && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1'b1);
    end else begin
      r_run <= 1'b0;
    end
  end

  assign o_expire = r_run & (r_cnt == '0);

endmodule

// File: rtl/dll_rx_ack_gen.sv
// dll_rx_ack_gen: receive-side DLL sequence checker. Forwards in-order good
// TLPs, discards bad/duplicate/ahead ones and schedules ACK/NAK DLLPs for
// the replay buffer.
// Build option: define ACK_COALESCE_EN to coalesce ACKs behind an
// ACK_LAT-cycle timer; without it every good TLP is ACKed immediately.
module dll_rx_ack_gen
  import dll_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int ACK_LAT = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  dll_rx_ack_gen_if.slave  if_bus
);

  rx_state_t         r_state;
  rx_state_t         w_state_nxt;
  logic [SEQ_W-1:0]  r_next_seq;
  logic              r_nak_sched;
  logic [SEQ_W-1:0]  r_ack_seq;
  logic [SEQ_W-1:0]  w_ack_seq_nxt;
  logic [DATA_W-1:0] r_dout;
  logic              r_dout_valid;
  logic              r_dllp_valid;
  ack_nak_t          r_ack_nak;
  logic              r_tlp_ready;

  logic              w_accept;
  logic [SEQ_W-1:0]  w_dist;
  logic [SEQ_W-1:0]  w_seq_last;
  logic              w_crc;
  logic              w_good;
  logic              w_dup;
  logic              w_ahead;
  logic              w_nak_now;
  logic              w_send_nxt;

`ifdef ACK_COALESCE_EN
  logic              w_expire;
  logic              w_tmr_start;
  logic              w_tmr_clear;
  logic              r_ack_pend;
  logic [SEQ_W-1:0]  r_pend_seq;
`endif

  // TLP classification: CRC error, in-order, duplicate (behind), or ahead
  assign w_accept   = if_bus.tlp_valid & r_tlp_ready;
  assign w_dist     = seq_dist(r_next_seq, if_bus.tlp_seq);
  assign w_seq_last = r_next_seq - SEQ_W'(1'b1);
  assign w_crc      = w_accept & if_bus.tlp_crc_err;
  assign w_good     = w_accept & ~if_bus.tlp_crc_err & (w_dist == '0);
  assign w_dup      = w_accept & ~if_bus.tlp_crc_err & (w_dist != '0) & (w_dist <= DUP_WIN);
  assign w_ahead    = w_accept & ~if_bus.tlp_crc_err & (w_dist > DUP_WIN);
  // Only the first bad TLP after a good one raises a NAK
  assign w_nak_now  = (w_crc | w_ahead) & ~r_nak_sched;
  assign w_send_nxt = (w_state_nxt == ST_SEND_ACK) | (w_state_nxt == ST_SEND_NAK);

`ifdef ACK_COALESCE_EN
  // Timer runs from the first good TLP of a window; later ones do not restart it
  assign w_tmr_start = w_good & (r_state == ST_IDLE);
  assign w_tmr_clear = (r_state == ST_ACK_PEND) & (w_state_nxt != ST_ACK_PEND);

  dll_ack_timer #(
    .ACK_LAT (ACK_LAT)
  ) u_ack_timer (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_start  (w_tmr_start),
    .i_clear  (w_tmr_clear),
    .o_expire (w_expire)
  );

  // Pending-ACK bookkeeping; any DLLP send or NAK drops the pending ACK
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ack_pend <= 1'b0;
      r_pend_seq <= '0;
    end else begin
      r_ack_pend <= (w_state_nxt == ST_ACK_PEND);
      if (w_good) begin
        r_pend_seq <= if_bus.tlp_seq;
      end
    end
  end
`endif

  // Next state and DLLP sequence: NAK over duplicate-ACK over new data over timer
  always_comb begin
    w_state_nxt   = r_state;
    w_ack_seq_nxt = r_ack_seq;
    case (r_state)
      ST_IDLE, ST_ACK_PEND: begin
        if (w_nak_now) begin
          w_state_nxt   = ST_SEND_NAK;
          w_ack_seq_nxt = w_seq_last;
        end else if (w_dup) begin
          w_state_nxt   = ST_SEND_ACK;
          w_ack_seq_nxt = w_seq_last;
        end else if (w_good) begin
`ifdef ACK_COALESCE_EN
          if (w_expire) begin
            w_state_nxt   = ST_SEND_ACK;
            w_ack_seq_nxt = if_bus.tlp_seq;
          end else begin
            w_state_nxt   = ST_ACK_PEND;
          end
        end else if (w_expire && r_ack_pend) begin
          w_state_nxt   = ST_SEND_ACK;
          w_ack_seq_nxt = r_pend_seq;
`else
          w_state_nxt   = ST_SEND_ACK;
          w_ack_seq_nxt = if_bus.tlp_seq;
`endif
        end else begin
          w_state_nxt   = r_state;
        end
      end
      ST_SEND_ACK, ST_SEND_NAK: begin
        if (if_bus.dllp_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state plus DLLP/ready outputs registered from the next state
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_ack_seq    <= '0;
      r_dllp_valid <= 1'b0;
      r_ack_nak    <= NONE;
      r_tlp_ready  <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_ack_seq    <= w_ack_seq_nxt;
      r_dllp_valid <= w_send_nxt;
      r_tlp_ready  <= ~w_send_nxt;
      case (w_state_nxt)
        ST_SEND_ACK: r_ack_nak <= ACK;
        ST_SEND_NAK: r_ack_nak <= NAK;
        default:     r_ack_nak <= NONE;
      endcase
    end
  end

  // Receive datapath: expected sequence, NAK suppression flag, forwarded payload
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_next_seq   <= '0;
      r_nak_sched  <= 1'b0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      r_dout_valid <= w_good;
      if (w_good) begin
        r_dout      <= if_bus.din;
        r_next_seq  <= r_next_seq + SEQ_W'(1'b1);
        r_nak_sched <= 1'b0;
      end else if (w_nak_now) begin
        r_nak_sched <= 1'b1;
      end
    end
  end

  assign if_bus.tlp_ready  = r_tlp_ready;
  assign if_bus.dout       = r_dout;
  assign if_bus.dout_valid = r_dout_valid;
  assign if_bus.dllp_valid = r_dllp_valid;
  assign if_bus.ack_nak    = r_ack_nak;
  assign if_bus.ack_seq    = r_ack_seq;

endmodule
